// File: rtl/eth_frame_matcher_n_if.sv
// eth_frame_matcher_n_if: RX byte-stream tap plus log-readout handshake
interface eth_frame_matcher_n_if #(
    parameter int C_NUM_PATTERNS = 4
);
    logic [7:0] s_axis_tdata;
    logic s_axis_tuser;
    logic s_axis_tlast;
    logic s_axis_tvalid;
    logic log_valid;
    logic log_ready;
    logic [63:0] log_time;
    logic [C_NUM_PATTERNS-1:0] log_match;
    logic [15:0] log_length;
    modport master (
        output s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid, log_ready,
        input log_valid, log_time, log_match, log_length
    );
    modport slave (
        input s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid, log_ready,
        output log_valid, log_time, log_match, log_length
    );
endinterface

// File: rtl/eth_frame_matcher_n.sv
// eth_frame_matcher_n: masked multi-pattern frame-header matcher with timestamped log FIFO
module eth_frame_matcher_n #(
    parameter int C_NUM_PATTERNS = 4,
    parameter int C_PATTERN_LEN = 128,
    parameter int C_LOG_DEPTH = 16,
    localparam int IW = C_NUM_PATTERNS > 1 ? $clog2(C_NUM_PATTERNS) : 1,
    localparam int OW = $clog2(C_PATTERN_LEN),
    localparam int AW = $clog2(C_LOG_DEPTH)
) (
    input logic clk,
    input logic rst,
    input logic cfg_we,
    input logic [IW-1:0] cfg_idx,
    input logic [OW-1:0] cfg_offset,
    input logic [7:0] cfg_data,
    input logic [7:0] cfg_mask,
    input logic cfg_len_we,
    input logic [OW:0] cfg_len,
    input logic [C_NUM_PATTERNS-1:0] cfg_enable,
    input logic [63:0] current_time,
    input logic time_running,
    eth_frame_matcher_n_if.slave bus,
    output logic [31:0] overflow_count,
    output logic [31:0] bad_frame_count
);
    localparam int N = C_NUM_PATTERNS;
    typedef enum logic [1:0] {SYNC, IDLE, RECV} state_t;
    state_t state, state_nx;
    logic [7:0] pat [N][C_PATTERN_LEN];
    logic [7:0] msk [N][C_PATTERN_LEN];
    logic [OW:0] len [N];
    logic [N-1:0] hit_r, en_r, hit_nx, en_nx, match, e_match;
    logic [63:0] time_r, time_nx, e_time;
    logic [15:0] count, count_nx, off, e_len;
    logic beat, eof, push_r, push, pop, full;
    logic [63:0] f_time [C_LOG_DEPTH];
    logic [N-1:0] f_match [C_LOG_DEPTH];
    logic [15:0] f_len [C_LOG_DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0] used;

    assign beat = bus.s_axis_tvalid;
    assign eof = beat && state != SYNC && bus.s_axis_tlast;
    assign off = state == IDLE ? 16'd0 : count;
    assign count_nx = state == IDLE ? 16'd1 : count + {15'd0, count != 16'hffff};
    assign en_nx = state == IDLE ? cfg_enable : en_r;
    assign time_nx = state == IDLE ? current_time : time_r;

    // Pattern, mask and length tables, written by the register block
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            pat[cfg_idx][cfg_offset] <= cfg_data;
            msk[cfg_idx][cfg_offset] <= cfg_mask;
        end
        if (cfg_len_we) len[cfg_idx] <= cfg_len;
    end

    // Per-pattern running hit including the current beat, and the end-of-frame verdict
    always_comb begin
        hit_nx = '0;
        match = '0;
        for (int i = 0; i < N; i++) begin
            hit_nx[i] = (state == IDLE || hit_r[i]) && (off >= 16'(C_PATTERN_LEN) ||
                ((bus.s_axis_tdata ^ pat[i][off[OW-1:0]]) & msk[i][off[OW-1:0]]) == 8'd0);
            match[i] = hit_nx[i] && en_nx[i] && count_nx >= 16'(len[i]);
        end
    end

    // Frame-alignment state register
    always_ff @(posedge clk) begin
        if (rst) state <= SYNC;
        else state <= state_nx;
    end

    // Any tlast realigns to a frame boundary; a non-final beat in IDLE opens a frame
    always_comb begin
        state_nx = state;
        if (beat && bus.s_axis_tlast) state_nx = IDLE;
        else if (beat && state == IDLE) state_nx = RECV;
    end

    // Per-frame accumulators, only meaningful while aligned
    always_ff @(posedge clk) begin
        if (beat && state != SYNC) begin
            hit_r <= hit_nx;
            en_r <= en_nx;
            time_r <= time_nx;
            count <= count_nx;
        end
    end

    // Register the end-of-frame result and count bad frames
    always_ff @(posedge clk) begin
        if (rst) begin
            push_r <= 1'b0;
            bad_frame_count <= '0;
        end else begin
            push_r <= eof && !bus.s_axis_tuser && |match && time_running;
            if (eof && bus.s_axis_tuser && bad_frame_count != '1) bad_frame_count <= bad_frame_count + 32'd1;
        end
    end

    // Log entry payload captured alongside the push request
    always_ff @(posedge clk) begin
        if (eof) begin
            e_time <= time_nx;
            e_match <= match;
            e_len <= count_nx;
        end
    end

    assign pop = bus.log_valid && bus.log_ready;
    assign full = used == (AW+1)'(C_LOG_DEPTH);
    assign push = push_r && (!full || pop);

    // FIFO pointers, occupancy and overflow accounting; a pop frees room for a same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
            used <= '0;
            overflow_count <= '0;
        end else begin
            if (push) wr <= wr + AW'(1);
            if (pop) rd <= rd + AW'(1);
            used <= used + (AW+1)'(push) - (AW+1)'(pop);
            if (push_r && !push && overflow_count != '1) overflow_count <= overflow_count + 32'd1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            f_time[wr] <= e_time;
            f_match[wr] <= e_match;
            f_len[wr] <= e_len;
        end
    end

    assign bus.log_valid = used != '0;
    assign bus.log_time = bus.log_valid ? f_time[rd] : '0;
    assign bus.log_match = bus.log_valid ? f_match[rd] : '0;
    assign bus.log_length = bus.log_valid ? f_len[rd] : '0;
endmodule

// File: tb/tb_eth_frame_matcher_n.sv
// tb_eth_frame_matcher_n: directed and randomized frames checked against a frame-level reference model
module tb_eth_frame_matcher_n;
    localparam int N = 4, L = 128, D = 16;
    typedef struct {
        logic [63:0] t;
        logic [3:0] m;
        logic [15:0] len;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_we = 1'b0, cfg_len_we = 1'b0, time_running = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [6:0] cfg_offset = '0;
    logic [7:0] cfg_data = '0, cfg_mask = '0, cfg_len = '0;
    logic [3:0] cfg_enable = '0;
    logic [63:0] current_time = '0;
    logic [31:0] overflow_count, bad_frame_count;

    eth_frame_matcher_n_if #(.C_NUM_PATTERNS(N)) bus ();

    eth_frame_matcher_n #(.C_NUM_PATTERNS(N), .C_PATTERN_LEN(L), .C_LOG_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_offset(cfg_offset),
        .cfg_data(cfg_data), .cfg_mask(cfg_mask),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_enable(cfg_enable),
        .current_time(current_time), .time_running(time_running),
        .bus(bus),
        .overflow_count(overflow_count), .bad_frame_count(bad_frame_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [7:0] mp [N][L];
    logic [7:0] mm [N][L];
    int ml [N];
    logic [7:0] fr [$];
    ent_t expq [$];
    int exp_ovf = 0, exp_bad = 0;
    bit synced = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_pat(input int i, input int o, input logic [7:0] d, input logic [7:0] m);
        cfg_we = 1'b1; cfg_idx = 2'(i); cfg_offset = 7'(o); cfg_data = d; cfg_mask = m;
        step();
        cfg_we = 1'b0;
        mp[i][o] = d;
        mm[i][o] = m;
    endtask

    task automatic set_len(input int i, input int n);
        cfg_len_we = 1'b1; cfg_idx = 2'(i); cfg_len = 8'(n);
        step();
        cfg_len_we = 1'b0;
        ml[i] = n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        expq.delete();
        exp_ovf = 0;
        exp_bad = 0;
        synced = 0;
    endtask

    // Random frame of n bytes; if hdr >= 0 the masked bits of pattern hdr are forced to agree
    task automatic mk_frame(input int n, input int hdr);
        fr.delete();
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (hdr >= 0 && k < L) b = (b & ~mm[hdr][k]) | (mp[hdr][k] & mm[hdr][k]);
            fr.push_back(b);
        end
    endtask

    // Reference verdict: a pattern matches when every compared byte agrees under its mask
    function automatic logic [3:0] model_match(input logic [3:0] en);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            bit hit;
            hit = 1;
            for (int k = 0; k < fr.size() && k < L; k++)
                if (((fr[k] ^ mp[i][k]) & mm[i][k]) != 8'd0) hit = 0;
            m[i] = hit && en[i] && fr.size() >= ml[i];
        end
        return m;
    endfunction

    // Drive beats a..b-1 of fr back to back; optionally scramble cfg_enable after each beat
    task automatic drive(input int a, input int b, input bit last, input logic [63:0] t0, input bit flip);
        for (int k = a; k < b; k++) begin
            bus.s_axis_tdata = fr[k];
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast = last && k == b - 1;
            current_time = t0 + 64'(k);
            step();
            if (flip) cfg_enable = 4'($urandom);
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast = 1'b0;
        bus.s_axis_tuser = 1'b0;
    endtask

    task automatic send(input bit tu, input logic [63:0] t0, input logic [3:0] en, input bit flip);
        logic [3:0] m;
        ent_t e;
        cfg_enable = en;
        m = model_match(en);
        if (fr.size() > 1) drive(0, fr.size() - 1, 0, t0, flip);
        bus.s_axis_tuser = tu;
        drive(fr.size() - 1, fr.size(), 1, t0, flip);
        if (!synced) synced = 1;
        else if (tu) exp_bad++;
        else if (m != 4'd0 && time_running) begin
            if (expq.size() == D) exp_ovf++;
            else begin
                e.t = t0; e.m = m; e.len = 16'(fr.size());
                expq.push_back(e);
            end
        end
    endtask

    task automatic drain();
        ent_t e;
        step();
        step();
        chk("overflow_count", 64'(overflow_count), 64'(exp_ovf));
        chk("bad_frame_count", 64'(bad_frame_count), 64'(exp_bad));
        bus.log_ready = 1'b1;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            chk("log_valid", 64'(bus.log_valid), 64'd1);
            chk("log_time", bus.log_time, e.t);
            chk("log_match", 64'(bus.log_match), 64'(e.m));
            chk("log_length", 64'(bus.log_length), 64'(e.len));
            step();
        end
        bus.log_ready = 1'b0;
        chk("log_empty", 64'(bus.log_valid), 64'd0);
    endtask

    initial begin
        bus.s_axis_tdata = '0;
        bus.s_axis_tuser = 1'b0;
        bus.s_axis_tlast = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.log_ready = 1'b0;
        do_reset();
        chk("rst_log_valid", 64'(bus.log_valid), 64'd0);
        chk("rst_log_time", bus.log_time, 64'd0);
        chk("rst_log_match", 64'(bus.log_match), 64'd0);
        chk("rst_log_length", 64'(bus.log_length), 64'd0);
        chk("rst_overflow", 64'(overflow_count), 64'd0);
        chk("rst_bad", 64'(bad_frame_count), 64'd0);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < L; k++) set_pat(i, k, 8'h00, 8'h00);
            set_len(i, 0);
        end
        time_running = 1'b1;
        // first frame after reset only realigns; then broadcast dst MAC on pattern 0
        mk_frame(60, -1);
        send(0, 64'd500, 4'b0001, 0);
        for (int k = 0; k < 6; k++) set_pat(0, k, 8'hff, 8'hff);
        set_len(0, 6);
        mk_frame(64, 0);
        send(0, 64'd1000, 4'b0001, 0);
        chk("log_valid_t1", 64'(bus.log_valid), 64'd0);
        step();
        chk("log_valid_t2", 64'(bus.log_valid), 64'd1);
        drain();
        // IPv4 ethertype with minimum length 14
        set_pat(1, 12, 8'h08, 8'hff);
        set_pat(1, 13, 8'h00, 8'hff);
        set_len(1, 14);
        mk_frame(10, 1);
        send(0, 64'd2000, 4'b0010, 0);
        mk_frame(14, 1);
        send(0, 64'd2100, 4'b0010, 0);
        drain();
        mk_frame(14, 1);
        send(1, 64'd3000, 4'b0010, 0);
        drain();
        // 17 back-to-back matches into a 16-deep log
        for (int f = 0; f < 17; f++) begin
            mk_frame(14 + int'($urandom_range(0, 30)), 0);
            send(0, 64'(4000 + 100 * f), 4'b0001, 0);
        end
        drain();
        time_running = 1'b0;
        mk_frame(20, 0);
        send(0, 64'd5000, 4'b0001, 0);
        time_running = 1'b1;
        mk_frame(20, -1);
        send(0, 64'd5100, 4'b0000, 0);
        mk_frame(2000, 0);
        send(0, 64'd6000, 4'b0001, 0);
        drain();
        // reset in the middle of a frame with an entry already queued
        mk_frame(20, 0);
        send(0, 64'd7000, 4'b0001, 0);
        mk_frame(50, 0);
        drive(0, 30, 0, 64'd7500, 0);
        do_reset();
        chk("midrst_log_valid", 64'(bus.log_valid), 64'd0);
        chk("midrst_overflow", 64'(overflow_count), 64'd0);
        drive(30, 50, 1, 64'd7500, 0);
        synced = 1;
        mk_frame(25, 0);
        send(0, 64'd8000, 4'b0001, 0);
        drain();
        // randomized configuration, frames, enables and gaps
        for (int b = 0; b < 5; b++) begin
            for (int f = 0; f < 8; f++) begin
                int hdr;
                for (int w = 0; w < 2; w++) begin
                    int o;
                    o = $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(120, 127));
                    set_pat(int'($urandom_range(0, 3)), o, 8'($urandom), 8'($urandom));
                end
                if ($urandom_range(0, 3) == 0) set_len(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)));
                hdr = $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : -1;
                mk_frame(int'($urandom_range(1, 200)), hdr);
                time_running = $urandom_range(0, 3) != 0;
                send($urandom_range(0, 7) == 0, {$urandom, $urandom}, 4'($urandom), 1);
                repeat ($urandom_range(0, 2)) step();
            end
            time_running = 1'b1;
            drain();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
